calc_mailbox_ctrl: RTL and testbench
====================================

# calc_mailbox_ctrl

Sequencer and arbiter between the calculator keypad front-end and the ARM core's shared data memory. Latches the first operand, the operator and the second operand from front-end save pulses, and writes each word to its fixed mailbox address. It then raises a start flag, polls the core's done flag and reads back the result. The core always has priority on the single memory port; the controller uses only the cycles the core leaves idle.

## Interface
Parameters:
- NUM1_ADDR, 32'd16, mailbox word for first operand
- OP_ADDR, 32'd20, mailbox word for operator code
- NUM2_ADDR, 32'd24, mailbox word for second operand
- START_ADDR, 32'd28, start flag written with 1 by controller
- DONE_ADDR, 32'd32, done flag set by core, cleared by controller
- RES_ADDR, 32'd36, result word written by core
- POLL_GAP, 8, idle cycles between done-flag polls (>=1)

Ports:
- clk  in  1  single clock; all state updates on posedge. Only clock in the block.
- rst  in  1  reset, synchronous, active-high
- save_num  in  1  one-cycle pulse: latch num_in into next operand slot
- save_op  in  1  one-cycle pulse: latch op_in
- num_in  in  32  operand value
- op_in  in  32  operator code
- core_req  in  1  core requests memory port this cycle
- core_we  in  1  core write enable
- core_addr  in  32  core address
- core_wdata  in  32  core write data
- core_grant  out  1  equals core_req (core never stalls)
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after the address (synchronous RAM); also routed to the core unchanged
- result  out  32  last captured result
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  transaction in progress
- err_overrun  out  1  sticky, set by a rejected save pulse

## Operation
- Port mux (combinational): if core_req=1, mem_* = core_*. Otherwise mem_* = the controller request. The controller request is idle (we=0, addr=0, wdata=0) in states with no access.
- An access is *issued* only in a cycle with core_req=0. A blocked access is retried each cycle with unchanged state.
- Operand capture:
  - save_num with slot counter 0 loads num1 and sets pend1; the counter goes to 1.
  - save_num with slot counter 1 loads num2 and sets pend2.
  - save_op loads op and sets pendop.
  - save_num and save_op in the same cycle are both accepted.
  - Any save pulse whose slot is already latched (including after num2 while the transaction runs) is ignored and sets err_overrun.
- busy is set on the first accepted save. It clears when the FSM returns to IDLE after CLR_DONE.
- FSM states:
  - IDLE: issue pending writes, priority pend1 -> pendop -> pend2, one per granted cycle. Each issued write clears its pend flag. After all three are written, go to WR_START.
  - WR_START: write 1 to START_ADDR -> POLL_WAIT (counter loaded with POLL_GAP).
  - POLL_WAIT: decrement the counter; at 0 -> POLL_RD.
  - POLL_RD: read DONE_ADDR -> POLL_CHK.
  - POLL_CHK: sample mem_rdata[0]. If 1 -> RES_RD. If 0 -> POLL_WAIT (counter reloaded).
  - RES_RD: read RES_ADDR -> RES_CAP.
  - RES_CAP: result <= mem_rdata, pulse result_valid -> CLR_DONE.
  - CLR_DONE: write 0 to DONE_ADDR -> IDLE. Clears slot counter and busy.
- Read data is captured in the cycle after issue, independent of core_req in the capture cycle.
- Only bit 0 of the done word is significant. All data is 32-bit; no arithmetic beyond counters.

## Timing
- Reset values: result=0, result_valid=0, busy=0, err_overrun=0, state IDLE, slot counter 0, all pend flags 0. Controller request is idle, so mem_* = core_* gated by core_req.
- Reset mid-transaction abandons all state. Memory is not touched, so START/DONE words keep whatever was last written.
- Write latency: a save pulse sampled at edge N makes the write visible on mem_* in cycle N+1, if the port is free.
- Uncontended sequence (pulses at cycles 0, 1, 2):
  - writes to 16/20/24 in cycles 1/2/3
  - START write in cycle 4
  - first DONE read in cycle 5+POLL_GAP
- Done-flag-to-result: if the read in cycle R sees done=1, RES_ADDR is read in R+2, result_valid pulses in R+3, and the DONE clear is written in R+4.
- core_req held high stalls the FSM indefinitely with no lost or duplicated access.

## Test plan
- Uncontended: save_num(7), save_op(2), save_num(5) in cycles 0-2 -> writes 16←7, 20←2, 24←5, 28←1 in cycles 1-4; busy=1 from cycle 1.
- Poll/result: model the core setting word 32=1 and 36=12 after 20 cycles -> polls every POLL_GAP+2 cycles; result=12 with a one-cycle result_valid; next write is 32←0; busy drops.
- Contention: core_req=1 in cycles 2-6 during the operand writes -> mem_* shows core traffic; the controller writes resume in cycle 7 in order 20, 24, 28; core_grant=core_req.
- Simultaneous save_num(3) and save_op(4) in cycle 0 -> both latched; writes 16←3 in cycle 1 and 20←4 in cycle 2.
- Overrun: a third save_num(9) after num2 -> ignored; err_overrun=1 until rst; mailbox keeps 24←5.
- Reset in POLL_WAIT -> next cycle all outputs are at reset values and no controller access occurs; a new sequence runs normally.

Source files
------------

// File: rtl/calc_mailbox_ctrl.sv
// Calculator mailbox sequencer: posts operands to shared memory,
// kicks the core, polls its done flag and fetches the result.
module calc_mailbox_ctrl #(
  parameter logic [31:0] NUM1_ADDR  = 32'd16,
  parameter logic [31:0] OP_ADDR    = 32'd20,
  parameter logic [31:0] NUM2_ADDR  = 32'd24,
  parameter logic [31:0] START_ADDR = 32'd28,
  parameter logic [31:0] DONE_ADDR  = 32'd32,
  parameter logic [31:0] RES_ADDR   = 32'd36,
  parameter int          POLL_GAP   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        save_num,
  input  logic        save_op,
  input  logic [31:0] num_in,
  input  logic [31:0] op_in,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_grant,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        err_overrun
);

  localparam int CW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_START,
    S_POLL_WAIT,
    S_POLL_RD,
    S_POLL_CHK,
    S_RES_RD,
    S_RES_CAP,
    S_CLR_DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] gap_q, gap_nx;
  logic [1:0]    slot;
  logic          got_op;
  logic          pend1, pendop, pend2;
  logic [31:0]   num1, num2, op;
  logic [31:0]   res_q;
  logic          busy_q, err_q;

  logic          ctl_we;
  logic [31:0]   ctl_addr, ctl_wdata;
  logic          clr1, clrop, clr2, clr_txn;
  logic          go, last;
  logic          acc_num, acc_op, rej;

  assign go   = !core_req;
  assign last = (slot == 2'd2) && got_op &&
                $onehot({pend1, pendop, pend2});

  assign acc_num = save_num && (slot != 2'd2);
  assign acc_op  = save_op && !got_op;
  assign rej     = (save_num && (slot == 2'd2)) ||
                   (save_op && got_op);

  always_comb begin
    state_nx  = state;
    gap_nx    = gap_q;
    ctl_we    = 1'b0;
    ctl_addr  = '0;
    ctl_wdata = '0;
    clr1      = 1'b0;
    clrop     = 1'b0;
    clr2      = 1'b0;
    clr_txn   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pend1) begin
          ctl_we    = 1'b1;
          ctl_addr  = NUM1_ADDR;
          ctl_wdata = num1;
          clr1      = go;
        end else if (pendop) begin
          ctl_we    = 1'b1;
          ctl_addr  = OP_ADDR;
          ctl_wdata = op;
          clrop     = go;
        end else if (pend2) begin
          ctl_we    = 1'b1;
          ctl_addr  = NUM2_ADDR;
          ctl_wdata = num2;
          clr2      = go;
        end
        if (go && last)
          state_nx = S_WR_START;
      end
      S_WR_START: begin
        ctl_we    = 1'b1;
        ctl_addr  = START_ADDR;
        ctl_wdata = 32'd1;
        if (go) begin
          state_nx = S_POLL_WAIT;
          gap_nx   = CW'(POLL_GAP);
        end
      end
      S_POLL_WAIT: begin
        gap_nx = gap_q - CW'(1);
        if (gap_q == CW'(1))
          state_nx = S_POLL_RD;
      end
      S_POLL_RD: begin
        ctl_addr = DONE_ADDR;
        if (go)
          state_nx = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (mem_rdata[0]) begin
          state_nx = S_RES_RD;
        end else begin
          state_nx = S_POLL_WAIT;
          gap_nx   = CW'(POLL_GAP);
        end
      end
      S_RES_RD: begin
        ctl_addr = RES_ADDR;
        if (go)
          state_nx = S_RES_CAP;
      end
      S_RES_CAP: begin
        state_nx = S_CLR_DONE;
      end
      S_CLR_DONE: begin
        ctl_we   = 1'b1;
        ctl_addr = DONE_ADDR;
        if (go) begin
          state_nx = S_IDLE;
          clr_txn  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      gap_q  <= '0;
      slot   <= 2'd0;
      got_op <= 1'b0;
      pend1  <= 1'b0;
      pendop <= 1'b0;
      pend2  <= 1'b0;
      num1   <= '0;
      num2   <= '0;
      op     <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      gap_q <= gap_nx;
      if (clr1)  pend1  <= 1'b0;
      if (clrop) pendop <= 1'b0;
      if (clr2)  pend2  <= 1'b0;
      if (acc_num) begin
        if (slot == 2'd0) begin
          num1  <= num_in;
          pend1 <= 1'b1;
          slot  <= 2'd1;
        end else begin
          num2  <= num_in;
          pend2 <= 1'b1;
          slot  <= 2'd2;
        end
      end
      if (acc_op) begin
        op     <= op_in;
        pendop <= 1'b1;
        got_op <= 1'b1;
      end
      if (acc_num || acc_op) busy_q <= 1'b1;
      if (rej) err_q <= 1'b1;
      // Slots reopen only once the done flag is cleared
      if (clr_txn) begin
        slot   <= 2'd0;
        got_op <= 1'b0;
        busy_q <= 1'b0;
      end
      if (state == S_RES_CAP) res_q <= mem_rdata;
    end
  end

  assign core_grant = core_req;
  assign mem_we     = core_req ? core_we    : ctl_we;
  assign mem_addr   = core_req ? core_addr  : ctl_addr;
  assign mem_wdata  = core_req ? core_wdata : ctl_wdata;

  // Result is shown live during the pulse so it is valid with result_valid
  assign result_valid = (state == S_RES_CAP);
  assign result       = result_valid ? mem_rdata : res_q;
  assign busy         = busy_q;
  assign err_overrun  = err_q;

endmodule

// File: tb/tb_calc_mailbox_ctrl.sv
// Bench for calc_mailbox_ctrl: synchronous RAM plus core model,
// access stream checked against a cycle-scheduled reference.
module tb_calc_mailbox_ctrl;

  localparam int G = 8;

  typedef struct {
    int          k;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        save_num = 1'b0;
  logic        save_op = 1'b0;
  logic [31:0] num_in = '0;
  logic [31:0] op_in = '0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_grant;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        err_overrun;

  logic [31:0] ram [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  bit ovr_st = 1'b0;

  acc_t        obs[$];
  acc_t        exp_q[$];
  int          rv_k[$];
  logic [31:0] rv_v[$];

  calc_mailbox_ctrl #(.POLL_GAP(G)) dut (
    .clk(clk), .rst(rst),
    .save_num(save_num), .save_op(save_op),
    .num_in(num_in), .op_in(op_in),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_grant(core_grant),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .result(result), .result_valid(result_valid),
    .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic acc_t mk(input int k, input logic we,
                              input logic [31:0] a,
                              input logic [31:0] d);
    acc_t e;
    e.k = k;
    e.we = we;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    chk("grant", core_grant, core_req);
    if (core_req) begin
      chk("mux_we", mem_we, core_we);
      chk("mux_addr", mem_addr, core_addr);
      chk("mux_wdata", mem_wdata, core_wdata);
    end else if (!rst && (mem_we || mem_addr != 0)) begin
      obs.push_back(mk(cyc - c0, mem_we, mem_addr, mem_wdata));
    end
    if (result_valid) begin
      rv_k.push_back(cyc - c0);
      rv_v.push_back(result);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input bit simul, input logic [31:0] n1,
                         input logic [31:0] op, input logic [31:0] n2,
                         input int blo, input int bhi, input int dd,
                         input bit ovr, input bit rmid);
    bit          blk[int];
    int          sc[3];
    logic [31:0] av[3];
    logic [31:0] dv[3];
    int          t, r, rr, pk, cl, lim, n;
    logic [31:0] res;
    res = $urandom;
    exp_q.delete();
    obs.delete();
    rv_k.delete();
    rv_v.delete();
    for (int k = blo; k <= bhi; k++) blk[k] = 1'b1;
    blk[dd - 1] = 1'b1;
    blk[dd] = 1'b1;
    if (simul) begin
      sc[0] = 0; sc[1] = 0; sc[2] = 1;
    end else begin
      sc[0] = 0; sc[1] = 1; sc[2] = 2;
    end
    av[0] = 32'd16; av[1] = 32'd20; av[2] = 32'd24;
    dv[0] = n1; dv[1] = op; dv[2] = n2;
    // Each access takes the first core-free cycle after its earliest slot
    t = -1;
    for (int i = 0; i < 3; i++) begin
      t = (sc[i] + 1 > t + 1) ? sc[i] + 1 : t + 1;
      while (blk.exists(t)) t++;
      exp_q.push_back(mk(t, 1'b1, av[i], dv[i]));
    end
    t = t + 1;
    while (blk.exists(t)) t++;
    exp_q.push_back(mk(t, 1'b1, 32'd28, 32'd1));
    r = t + G + 1;
    while (blk.exists(r)) r++;
    forever begin
      exp_q.push_back(mk(r, 1'b0, 32'd32, 32'd0));
      if (r > dd) break;
      r = r + G + 2;
      while (blk.exists(r)) r++;
    end
    rr = r + 2;
    while (blk.exists(rr)) rr++;
    exp_q.push_back(mk(rr, 1'b0, 32'd36, 32'd0));
    pk = rr + 1;
    cl = rr + 2;
    while (blk.exists(cl)) cl++;
    exp_q.push_back(mk(cl, 1'b1, 32'd32, 32'd0));
    lim = rmid ? 9 : cl + 3;
    c0 = cyc;
    for (int k = 0; k < lim; k++) begin
      save_num = 1'b0; save_op = 1'b0; rst = 1'b0;
      core_req = 1'b0; core_we = 1'b0;
      core_addr = '0; core_wdata = '0;
      if (simul) begin
        if (k == 0) begin
          save_num = 1'b1; num_in = n1;
          save_op = 1'b1; op_in = op;
        end else if (k == 1) begin
          save_num = 1'b1; num_in = n2;
        end
      end else begin
        if (k == 0) begin save_num = 1'b1; num_in = n1; end
        if (k == 1) begin save_op = 1'b1; op_in = op; end
        if (k == 2) begin save_num = 1'b1; num_in = n2; end
      end
      if (ovr && k == 3) begin save_num = 1'b1; num_in = $urandom; end
      if (k >= blo && k <= bhi) begin
        core_req = 1'b1;
        core_we = 1'($urandom_range(0, 1));
        core_addr = 32'(64 + 4 * $urandom_range(0, 15));
        core_wdata = $urandom;
      end
      if (k == dd - 1) begin
        core_req = 1'b1; core_we = 1'b1;
        core_addr = 32'd36; core_wdata = res;
      end
      if (k == dd) begin
        core_req = 1'b1; core_we = 1'b1;
        core_addr = 32'd32; core_wdata = 32'd1;
      end
      if (rmid && k == 7) rst = 1'b1;
      @(negedge clk);
      if (!rmid) begin
        if (k == 1) chk("busy_start", busy, 1);
        if (k == cl) chk("busy_hold", busy, 1);
        if (k == cl + 1) chk("busy_off", busy, 0);
      end
      if (rmid && k == 8) begin
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err_overrun, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
      end
      @(posedge clk);
      #1;
    end
    save_num = 1'b0; save_op = 1'b0; rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0;
    core_addr = '0; core_wdata = '0;
    if (rmid) begin
      repeat (10) step();
      chk("rst_quiet", obs.size(), 4);
      ovr_st = 1'b0;
      return;
    end
    chk("acc_count", obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("acc_cycle", obs[i].k, exp_q[i].k);
      chk("acc_we", obs[i].we, exp_q[i].we);
      chk("acc_addr", obs[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk("acc_data", obs[i].data, exp_q[i].data);
    end
    chk("rv_count", rv_k.size(), 1);
    if (rv_k.size() > 0) begin
      chk("rv_cycle", rv_k[0], pk);
      chk("rv_value", rv_v[0], res);
    end
    chk("result_hold", result, res);
    if (ovr) ovr_st = 1'b1;
    chk("overrun", err_overrun, ovr_st);
    chk("mbox_num2", ram[6], n2);
  endtask

  initial begin
    int lo;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_err", err_overrun, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step();

    run_txn(1'b0, 32'd7, 32'd2, 32'd5, -10, -10, 21, 1'b0, 1'b0);
    run_txn(1'b0, $urandom, $urandom, $urandom, 2, 6, 30, 1'b0, 1'b0);
    run_txn(1'b1, 32'd3, 32'd4, $urandom, -10, -10, 25, 1'b0, 1'b0);
    run_txn(1'b0, $urandom, $urandom, 32'd5, -10, -10, 22, 1'b1, 1'b0);
    run_txn(1'b0, $urandom, $urandom, $urandom, -10, -10, 1000, 1'b0, 1'b1);
    run_txn(1'b0, $urandom, $urandom, $urandom, -10, -10, 20, 1'b0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      lo = $urandom_range(0, 12);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              lo, lo + $urandom_range(0, 6), $urandom_range(5, 40),
              1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
